mem_responder: RTL and testbench

Single-port memory responder that answers instruction-fetch and load/store requests from the NPC core over a valid/ready request/response handshake. It holds a word-addressed storage array mapped at the reset PC region. It allows one outstanding transaction and adds a configurable response latency, so the core's fetch and LSU initiators can be exercised against a multi-cycle memory instead of a combinational lookup.

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory answering fetch/LSU requests, one transaction in flight.
// Latency: resp_valid sampled high LATENCY edges after acceptance (LATENCY+lfsr[1:0], sat 15, with MEM_RAND_DELAY_EN).
// Backpressure: req_ready only in IDLE; response held stable while resp_ready is low.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_CFG  = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  state_t      state;
  logic [3:0]  cnt;
  resp_t       resp_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic [3:0]    eff_lat;
  logic          unused_offset_bits;

  // Reset wins over a simultaneous request so nothing is half-accepted.
  assign accept   = (state == IDLE) && req_valid && !rst;
  // Addresses below BASE_ADDR wrap in the subtraction; the unsigned range compare catches them.
  assign offset   = req_addr - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign in_range = ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, req_addr} < END_ADDR);
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

`ifdef MEM_RAND_DELAY_EN
  logic [3:0] lfsr;
  logic [4:0] lat_sum;

  // Free-running x^4+x^3+1 LFSR that jitters the response latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 4'b1001;
    end else begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end

  assign lat_sum = {1'b0, LAT_CFG} + {3'b000, lfsr[1:0]};
  assign eff_lat = lat_sum[4] ? 4'hF : lat_sum[3:0];
`else
  assign eff_lat = LAT_CFG;
`endif

  // Transaction FSM: capture the response at acceptance, count down, hold until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      resp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_q.err   <= !in_range;
            resp_q.rdata <= (in_range && !req_wen) ? mem[idx] : 32'h0;
            if (eff_lat <= 4'd1) begin
              state <= RESP;
              cnt   <= 4'd0;
            end else begin
              state <= WAIT;
              cnt   <= eff_lat - 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state  <= IDLE;
            resp_q <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane writes commit at acceptance; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (accept && req_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wmask[b]) begin
          mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wmask  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_pass  = 0;
  int n_total = 0;

  mem_responder #(.LATENCY(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_wen    (req_wen[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .req_wmask  (req_wmask[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  mem_responder #(.LATENCY(5)) u_dut5 (
    .clk        (clk),
    .rst        (rst[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_wen    (req_wen[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .req_wmask  (req_wmask[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_req(input int s, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    req_valid[s] = v;
    req_wen[s]   = w;
    req_addr[s]  = a;
    req_wdata[s] = d;
    req_wmask[s] = m;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the handshake edge.
  // lat = number of edges from acceptance to the first edge that samples resp_valid high.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] rd, output logic er, output int lat);
    set_req(s, 1'b1, w, a, d, m);
    @(posedge clk); #1;
    set_req(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    lat = 1;
    while (!resp_valid[s] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata[s];
    er = resp_err[s];
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wait_cnt;
    logic        stale;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h8000_3FFC, 32'h0BAD_C0DE, 4'hF, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 32'h8000_4000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_3FFC, 32'h0000_0000, 4'h0, 32'h0BAD_C0DE, 1'b0};
    vecs[12] = '{1'b1, 32'h8000_0030, 32'h7654_3210, 4'hF, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 32'h8000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_0032, 32'h0000_0000, 4'h0, 32'h7654_3210, 1'b0};
    vecs[15] = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};

    for (int s = 0; s < 2; s++) begin
      rst[s]        = 1'b1;
      resp_ready[s] = 1'b0;
      set_req(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end

    // Reset, then idle.
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst_req_ready_c%0d", c), 32'(req_ready[0]), 32'd1);
      chk($sformatf("rst_resp_valid_c%0d", c), 32'(resp_valid[0]), 32'd0);
      chk($sformatf("rst_resp_rdata_c%0d", c), resp_rdata[0], 32'h0);
      chk($sformatf("rst_resp_err_c%0d", c), 32'(resp_err[0]), 32'd0);
      @(posedge clk); #1;
    end
    chk("rst_req_ready_lat5", 32'(req_ready[1]), 32'd1);

    // Table of LATENCY=3 transactions.
    for (int i = 0; i < 17; i++) begin
      txn(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ready_after", i), 32'(req_ready[0]), 32'd1);
    end

    // Backpressure: hold resp_ready low for 10 cycles while a stray write is presented.
    set_req(0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_cnt = 1;
    while (!resp_valid[0] && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("bp_first_valid", 32'(resp_valid[0]), 32'd1);
    set_req(0, 1'b1, 1'b1, 32'h8000_0010, 32'h0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", c), 32'(resp_valid[0]), 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), resp_rdata[0], 32'hDEAD_BEEF);
      chk($sformatf("bp_req_ready_c%0d", c), 32'(req_ready[0]), 32'd0);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    chk("bp_valid_after_hs", 32'(resp_valid[0]), 32'd0);
    chk("bp_req_ready_after_hs", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("bp_stray_write_ignored", rd, 32'hDEAD_BEEF);

    // Reset mid-WAIT on the LATENCY=5 instance; the accepted write must stay committed.
    set_req(1, 1'b1, 1'b1, 32'h8000_0040, 32'h5555_AAAA, 4'hF);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("midwait_req_ready_busy", 32'(req_ready[1]), 32'd0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("midwait_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("midwait_req_ready", 32'(req_ready[1]), 32'd1);
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (resp_valid[1] || !req_ready[1]) stale = 1'b1;
    end
    chk("midwait_no_stale_resp", 32'(stale), 32'd0);
    txn(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
    chk("lat5_latency", 32'(lat), 32'd5);
    chk("lat5_write_committed", rd, 32'h5555_AAAA);
    chk("lat5_err", 32'(er), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
